// File: rtl/ask_fsk_framer_if.sv
// Byte handshake between a payload source and ask_fsk_framer.
//   tx_data  : payload byte, source -> framer
//   tx_valid : tx_data valid, source -> framer
//   tx_ready : framer can accept a byte, framer -> source
// master modport = byte source, slave modport = framer.
interface ask_fsk_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ask_fsk_framer.sv
// ask_fsk_framer: frames accepted bytes as preamble + sync byte + payload byte
// and serialises them MSB-first with a companion bit clock for the ASK-FSK
// transmitter. Frames always start on the first bit of a pair (phase=0) and
// have even length.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   tx         : byte handshake (slave modport: tx_data, tx_valid in; tx_ready out)
//   bit_clk    : bit clock, rises mid-bit
//   bitstream  : serial frame data, IDLE_BIT between frames
//   busy       : byte accepted and frame not finished
//   frame_done : 1-cycle pulse when the last frame bit ends
//
// Optional feature macro: ASK_FSK_FRAMER_PARITY_EN
//   defined   -> even-parity bit plus one IDLE_BIT pad bit after the payload
//   undefined -> frame ends after the last payload bit
//
// PREAMBLE_BITS must not exceed 16 (the bit counter is 4 bits wide).
module ask_fsk_framer #(
  parameter int unsigned CLK_DIV       = 32,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter logic [7:0]  SYNC_WORD     = 8'hD5,
  parameter logic        IDLE_BIT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  ask_fsk_framer_if.slave  tx,
  output logic             bit_clk,
  output logic             bitstream,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_PREAMBLE,
    S_SYNC,
`ifdef ASK_FSK_FRAMER_PARITY_EN
    S_DATA,
    S_PARITY
`else
    S_DATA
`endif
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic             phase;
  logic [3:0]       cnt, cnt_n;
  logic [7:0]       sh, sh_n;
  logic [7:0]       data_q, data_n;
  logic             bits_n;
  logic             done_n;
  logic             boundary;
  logic             accept;

  assign boundary = (div == DIV_W'(CLK_DIV - 1));
  assign accept   = tx.tx_valid & tx.tx_ready;

  // Next-state / next-bit logic. The state names the field of the bit
  // currently on bitstream; the next bit is loaded at each bit boundary.
  always_comb begin
    div_n   = boundary ? '0 : div + DIV_W'(1);
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    data_n  = data_q;
    bits_n  = bitstream;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        bits_n = IDLE_BIT;
        if (accept) begin
          state_n = S_ALIGN;
          data_n  = tx.tx_data;
        end
      end

      // Wait for a boundary whose next bit is the first of a pair.
      S_ALIGN: begin
        if (boundary && phase) begin
          state_n = S_PREAMBLE;
          cnt_n   = 4'd0;
          bits_n  = 1'b1;
        end
      end

      S_PREAMBLE: begin
        if (boundary) begin
          if (cnt == 4'(PREAMBLE_BITS - 1)) begin
            state_n = S_SYNC;
            cnt_n   = 4'd0;
            bits_n  = SYNC_WORD[7];
            sh_n    = {SYNC_WORD[6:0], 1'b0};
          end else begin
            cnt_n  = cnt + 4'd1;
            bits_n = ~bitstream;
          end
        end
      end

      S_SYNC: begin
        if (boundary) begin
          if (cnt == 4'd7) begin
            state_n = S_DATA;
            cnt_n   = 4'd0;
            bits_n  = data_q[7];
            sh_n    = {data_q[6:0], 1'b0};
          end else begin
            cnt_n  = cnt + 4'd1;
            bits_n = sh[7];
            sh_n   = {sh[6:0], 1'b0};
          end
        end
      end

      S_DATA: begin
        if (boundary) begin
          if (cnt == 4'd7) begin
`ifdef ASK_FSK_FRAMER_PARITY_EN
            state_n = S_PARITY;
            cnt_n   = 4'd0;
            bits_n  = ^data_q;
`else
            state_n = S_IDLE;
            bits_n  = IDLE_BIT;
            done_n  = 1'b1;
`endif
          end else begin
            cnt_n  = cnt + 4'd1;
            bits_n = sh[7];
            sh_n   = {sh[6:0], 1'b0};
          end
        end
      end

`ifdef ASK_FSK_FRAMER_PARITY_EN
      // Parity bit, then one pad bit so the frame length stays even.
      S_PARITY: begin
        if (boundary) begin
          bits_n = IDLE_BIT;
          if (cnt == 4'd1) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
        bits_n  = IDLE_BIT;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      div         <= '0;
      phase       <= 1'b0;
      cnt         <= 4'd0;
      sh          <= 8'd0;
      data_q      <= 8'd0;
      bit_clk     <= 1'b0;
      bitstream   <= IDLE_BIT;
      tx.tx_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      phase       <= boundary ? ~phase : phase;
      cnt         <= cnt_n;
      sh          <= sh_n;
      data_q      <= data_n;
      bit_clk     <= (div_n >= DIV_W'(CLK_DIV / 2));
      bitstream   <= bits_n;
      tx.tx_ready <= (state_n == S_IDLE);
      // Held through the frame_done cycle even though the FSM is back in IDLE.
      busy        <= (state_n != S_IDLE) | done_n;
      frame_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_ask_fsk_framer.sv
// Testbench for ask_fsk_framer: a CLK_DIV=8 / PREAMBLE_BITS=4 instance for
// framing and handshake, and a default CLK_DIV=32 instance for bit timing.
// Expected frames come from a bit-list model built from the framing rules.
module tb_ask_fsk_framer;

  localparam int PRE = 4;
`ifdef ASK_FSK_FRAMER_PARITY_EN
  localparam int FL = PRE + 18;
`else
  localparam int FL = PRE + 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ask_fsk_framer_if if8 ();
  ask_fsk_framer_if if32 ();
  logic bclk8, bs8, busy8, fd8;
  logic bclk32, bs32, busy32, fd32;

  ask_fsk_framer #(.CLK_DIV(8), .PREAMBLE_BITS(4)) dut8 (
    .clk(clk), .rst(rst), .tx(if8.slave),
    .bit_clk(bclk8), .bitstream(bs8), .busy(busy8), .frame_done(fd8)
  );

  ask_fsk_framer dut32 (
    .clk(clk), .rst(rst), .tx(if32.slave),
    .bit_clk(bclk32), .bitstream(bs32), .busy(busy32), .frame_done(fd32)
  );

  int tests  = 0;
  int failed = 0;

  // Bits of dut8 sampled on each bit_clk rise since the last reset; the
  // queue index equals the bit's position since reset, so index%2 is phase.
  logic bits_q[$];
  logic prev_bclk8 = 1'b0;
  int   fd_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bits_q.delete();
      prev_bclk8 = 1'b0;
    end else begin
      if (bclk8 && !prev_bclk8) bits_q.push_back(bs8);
      prev_bclk8 = bclk8;
      if (fd8 === 1'b1) fd_cnt++;
    end
  end

  // Timing statistics of dut32 while armed.
  logic t6_on = 1'b0;
  int cyc = 0, prev_rise = -1, edge_t = -1;
  int min_per = 9999, max_per = 0, min_hi = 9999, max_hi = 0;
  int edge_bad = 0, edge_cnt = 0;
  logic prev_bs32 = 1'b0, prev_bclk32 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!t6_on) begin
      prev_rise = -1; edge_t = -1;
      min_per = 9999; max_per = 0; min_hi = 9999; max_hi = 0;
      edge_bad = 0; edge_cnt = 0;
    end else begin
      if (bs32 !== prev_bs32) begin
        edge_cnt++;
        edge_t = cyc;
      end
      if (bclk32 && !prev_bclk32) begin
        if (prev_rise >= 0) begin
          if (cyc - prev_rise < min_per) min_per = cyc - prev_rise;
          if (cyc - prev_rise > max_per) max_per = cyc - prev_rise;
        end
        prev_rise = cyc;
        if (edge_t >= 0) begin
          if (cyc - edge_t != 16) edge_bad++;
          edge_t = -1;
        end
      end
      if (!bclk32 && prev_bclk32 && prev_rise >= 0) begin
        if (cyc - prev_rise < min_hi) min_hi = cyc - prev_rise;
        if (cyc - prev_rise > max_hi) max_hi = cyc - prev_rise;
      end
    end
    prev_bs32   = bs32;
    prev_bclk32 = bclk32;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame, first bit in the MSB of the FL-bit field.
  function automatic logic [31:0] model(input logic [7:0] b);
    logic [31:0] r = '0;
    logic [7:0]  sync_w = 8'hD5;
    for (int i = 0; i < PRE; i++) r = {r[30:0], 1'(i % 2 == 0)};
    for (int i = 7; i >= 0; i--) r = {r[30:0], sync_w[i]};
    for (int i = 7; i >= 0; i--) r = {r[30:0], b[i]};
`ifdef ASK_FSK_FRAMER_PARITY_EN
    r = {r[30:0], 1'(b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7])};
    r = {r[30:0], 1'b0};
`endif
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready8(input string tag);
    int n = 0;
    while (if8.tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(if8.tx_ready), 32'd1);
  endtask

  task automatic wait_done8(input string tag);
    int n = 0;
    while (fd8 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(fd8), 32'd1);
  endtask

  // Single-byte send on dut8; returns the queue index at the accept.
  task automatic send8(input string tag, input logic [7:0] b, output int start);
    wait_ready8(tag);
    start = bits_q.size();
    if8.tx_data  = b;
    if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
  endtask

  // Locate the frame (first 1 at/after start), compare it and its phase.
  task automatic check_frame(input string tag, input int start, input logic [7:0] b,
                             output int s);
    logic [31:0] obs = '0;
    s = start;
    while (s < bits_q.size() && bits_q[s] !== 1'b1) s++;
    for (int i = 0; i < FL; i++)
      obs = {obs[30:0], (s + i < bits_q.size()) ? bits_q[s + i] : 1'bx};
    check({tag, "_bits"}, obs, model(b));
    check({tag, "_phase"}, 32'(s % 2), 32'd0);
  endtask

  initial begin
    int st, s1, s2, fd0, n;
    logic [7:0] b;
    if8.tx_valid = 1'b0; if8.tx_data = 8'h00;
    if32.tx_valid = 1'b0; if32.tx_data = 8'h00;

    // T1 reset
    step(3);
    check("rst_bit_clk", 32'(bclk8), 32'd0);
    check("rst_bitstream", 32'(bs8), 32'd0);
    check("rst_tx_ready", 32'(if8.tx_ready), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_frame_done", 32'(fd8), 32'd0);
    rst = 1'b0;
    step(1);
    check("rel_tx_ready", 32'(if8.tx_ready), 32'd1);

    // T2 single byte A5, then random bytes
    fd0 = fd_cnt;
    send8("a5", 8'hA5, st);
    check("a5_ready_low", 32'(if8.tx_ready), 32'd0);
    wait_done8("a5");
    check("a5_ready_in_done", 32'(if8.tx_ready), 32'd1);
    check("a5_busy_in_done", 32'(busy8), 32'd1);
    step(3);
    check("a5_one_pulse", 32'(fd_cnt - fd0), 32'd1);
    check("a5_busy_after", 32'(busy8), 32'd0);
    check_frame("a5", st, 8'hA5, s1);
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      fd0 = fd_cnt;
      send8("rnd", b, st);
      wait_done8("rnd");
      step(2);
      check("rnd_one_pulse", 32'(fd_cnt - fd0), 32'd1);
      check_frame("rnd", st, b, s1);
    end

    // T3 back-to-back 00 then FF with tx_valid held
    fd0 = fd_cnt;
    wait_ready8("b2b");
    st = bits_q.size();
    if8.tx_data = 8'h00; if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_data = 8'hFF;
    check("b2b_ready_low", 32'(if8.tx_ready), 32'd0);
    n = 0;
    while (if8.tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("b2b_ready_again", 32'(if8.tx_ready), 32'd1);
    check("b2b_accept_in_done", 32'(fd8), 32'd1);
    @(negedge clk);
    if8.tx_valid = 1'b0;
    check("b2b_second_taken", 32'(if8.tx_ready), 32'd0);
    check("b2b_busy", 32'(busy8), 32'd1);
    wait_done8("b2b2");
    step(2);
    check("b2b_pulses", 32'(fd_cnt - fd0), 32'd2);
    check_frame("b2b_f1", st, 8'h00, s1);
    check_frame("b2b_f2", s1 + FL, 8'hFF, s2);
    check("b2b_gap", 32'(s2 - (s1 + FL)), 32'd2);

    // T4 tx_valid while busy is ignored
    b = 8'($urandom);
    send8("vb", b, st);
    step(50);
    if8.tx_data = 8'h3C; if8.tx_valid = 1'b1;
    check("vb_ready_low", 32'(if8.tx_ready), 32'd0);
    @(negedge clk);
    if8.tx_valid = 1'b0;
    check("vb_ready_low2", 32'(if8.tx_ready), 32'd0);
    wait_done8("vb");
    check_frame("vb", st, b, s1);
    step(20);
    check("vb_not_consumed", 32'(busy8), 32'd0);

    // T5 reset during SYNC
    b = 8'($urandom);
    send8("mr", b, st);
    step(60);
    fd0 = fd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mr_bitstream", 32'(bs8), 32'd0);
    check("mr_busy", 32'(busy8), 32'd0);
    check("mr_ready", 32'(if8.tx_ready), 32'd0);
    check("mr_bit_clk", 32'(bclk8), 32'd0);
    rst = 1'b0;
    step(40);
    check("mr_no_done", 32'(fd_cnt - fd0), 32'd0);
    b = 8'($urandom);
    send8("mr2", b, st);
    wait_done8("mr2");
    check_frame("mr2", st, b, s1);

    // T6 bit timing on the CLK_DIV=32 instance
    t6_on = 1'b1;
    n = 0;
    while (if32.tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("t6_ready", 32'(if32.tx_ready), 32'd1);
    if32.tx_data = 8'($urandom); if32.tx_valid = 1'b1;
    @(negedge clk);
    if32.tx_valid = 1'b0;
    n = 0;
    while (fd32 !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("t6_done", 32'(fd32), 32'd1);
    step(40);
    check("t6_busy_after", 32'(busy32), 32'd0);
    check("t6_min_period", 32'(min_per), 32'd32);
    check("t6_max_period", 32'(max_per), 32'd32);
    check("t6_min_high", 32'(min_hi), 32'd16);
    check("t6_max_high", 32'(max_hi), 32'd16);
    check("t6_edges_seen", 32'(edge_cnt > 0), 32'd1);
    check("t6_edge_align", 32'(edge_bad), 32'd0);
    t6_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
